cones_fifo_sink: RTL and testbench
==================================

Name: cones_fifo_sink

Overview:
- Downstream consumer stage for the two-stage inverting register pipeline. Its `in_data` connects to that pipeline's 2-bit `out` through a valid/ready handshake.
- Buffers accepted words in a small first-word-fall-through FIFO and presents them on a valid/ready output.
- Keeps a running XOR checksum of every word popped, so the bench and the TMR flow have several independent sequential logic cones to exercise: pointers, level counter, storage and checksum.

Parameters:
- WIDTH, 2, data word width in bits (>=1).
- DEPTH, 4, FIFO entries; must be a power of two and >=2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  word from upstream pipeline
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  FIFO can accept a word this cycle
- out_data  output  WIDTH  head-of-FIFO word
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer takes out_data this cycle
- level  output  $clog2(DEPTH+1)  number of stored words
- xor_acc  output  WIDTH  XOR of all words popped since reset

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (rst_n); clk is the only clock.
  - rst_n low immediately forces, without waiting for a clock edge: level=0, read pointer=0, write pointer=0, all storage entries=0, xor_acc=0. Consequently out_valid=0, out_data=0 and in_ready=1.
  - Release is synchronous to clk; the first push is possible on the first rising edge with rst_n high.
  - Reset mid-operation discards all contents and the checksum; no partial state survives.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Transfers happen at the rising edge of clk.
  - in_ready = (level != DEPTH). It is a registered-state function only, with no combinational path from out_ready.
  - out_valid = (level != 0).
  - out_data = storage[read pointer]. It is valid whenever out_valid=1 and holds stable until popped.
- Latency: a word pushed into an empty FIFO at edge N appears on out_data with out_valid=1 after edge N. Minimum in-to-out latency is one cycle; there is no same-cycle fall-through.
- Push: storage[write pointer] <= in_data; write pointer increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Pop: read pointer increments modulo DEPTH; xor_acc <= xor_acc ^ out_data (the word being popped).
- Level update:
  - push only: level+1.
  - pop only: level-1.
  - push and pop in the same cycle: level unchanged, both pointers advance.
- Full (level==DEPTH):
  - in_ready=0 and in_valid is ignored, even if out_ready=1 in that same cycle.
  - A pop in that cycle takes level to DEPTH-1, so in_ready=1 on the next cycle.
- Empty (level==0):
  - out_valid=0 and out_ready is ignored.
  - xor_acc holds.
  - A simultaneous push is accepted normally.
- Ordering: strictly FIFO; no word is duplicated or dropped; never overflow or underflow.
- xor_acc wraps naturally in WIDTH bits; it is never cleared except by reset.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low for 2 cycles, then high; in_valid=0.
  - Required: level=0, out_valid=0, in_ready=1, out_data=2'b00, xor_acc=2'b00 throughout.
- Fill to full:
  - Stimulus: push 2'b01, 2'b10, 2'b11, 2'b00 on consecutive edges with out_ready=0; then hold in_valid=1 with in_data=2'b11.
  - Required: level goes 1,2,3,4; in_ready=0 after the 4th push; the 5th word is not stored; out_data=2'b01.
- Drain and checksum:
  - Stimulus: from the full state above, hold out_ready=1 for 4 cycles.
  - Required: out_data sequence 01,10,11,00; xor_acc after each pop 01,11,00,00; out_valid=0 and level=0 afterwards.
- Full with simultaneous pop/push request:
  - Stimulus: full with in_valid=1 and out_ready=1 in the same cycle.
  - Required: pop only, level 4->3; next cycle in_ready=1 and a push/pop pair keeps level=3 with both pointers advancing.
- Pointer wrap:
  - Stimulus: stream 10 words (pattern i mod 4) with in_valid=1 and out_ready=1 continuously.
  - Required: output order matches input order, 1-cycle latency, level stays <=1; xor_acc = XOR of all popped words (2'b01 after 10 pushes and 9 pops).
- Reset mid-operation:
  - Stimulus: level=3, then assert rst_n low between clock edges.
  - Required: out_valid, level and xor_acc drop to 0 immediately, before the next edge; after release the FIFO operates as after power-on.

Source files
------------

// File: rtl/cones_fifo_sink.sv
// cones_fifo_sink: first-word-fall-through FIFO sink with a running XOR
// checksum of every popped word.
// Ports: clk, rst_n (async, active-low); in_data/in_valid/in_ready (upstream);
// out_data/out_valid/out_ready (downstream); level (stored words);
// xor_acc (XOR of popped words since reset).
module cones_fifo_sink #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [WIDTH-1:0]           xor_acc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    wr_q;
    logic [LW-1:0]    lvl_q;
    logic [WIDTH-1:0] acc_q;
    logic             push;
    logic             pop;

    // Handshake depends on stored level only; out_ready never reaches in_ready.
    assign in_ready  = (lvl_q != FULL);
    assign out_valid = (lvl_q != '0);
    assign out_data  = mem[rd_q];
    assign level     = lvl_q;
    assign xor_acc   = acc_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            lvl_q <= '0;
            acc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_q] <= in_data;
                wr_q      <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q  <= rd_q + 1'b1;
                acc_q <= acc_q ^ mem[rd_q];
            end
            if (push && !pop) begin
                lvl_q <= lvl_q + 1'b1;
            end else if (pop && !push) begin
                lvl_q <= lvl_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cones_fifo_sink.sv
// tb_cones_fifo_sink: directed, table-driven bench for cones_fifo_sink.
// Vectors give inputs plus the outputs expected before the applying edge.
module tb_cones_fifo_sink;

    logic       clk;
    logic       rst_n;
    logic [1:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] level;
    logic [1:0] xor_acc;

    int errors = 0;
    int checks = 0;

    cones_fifo_sink #(.WIDTH(2), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .xor_acc   (xor_acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    typedef struct {
        logic       iv;
        logic [1:0] id;
        logic       ordy;
        logic [2:0] lvl;
        logic       ov;
        logic       ir;
        logic [1:0] od;
        logic [1:0] xa;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: act=%0h req=%0h", name, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] lvl,
                           input logic ov, input logic ir,
                           input logic [1:0] od, input logic [1:0] xa);
        chk({tag, ".level"}, 32'(level), 32'(lvl));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
        chk({tag, ".out_data"}, 32'(out_data), 32'(od));
        chk({tag, ".xor_acc"}, 32'(xor_acc), 32'(xa));
    endtask

    task automatic drive(input logic iv, input logic [1:0] id,
                         input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 2'b00;
        out_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_all("in_reset", 3'd0, 1'b0, 1'b1, 2'b00, 2'b00);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [1:0] q [$];
    logic [1:0] model_acc;
    logic [1:0] w;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 2'b00;
        out_ready = 1'b0;

        //         iv  id     ordy lvl   ov    ir    od     xa
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00, 2'b00};
        vecs[1]  = '{1'b1, 2'b01, 1'b0, 3'd0, 1'b0, 1'b1, 2'b00, 2'b00};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 3'd1, 1'b1, 1'b1, 2'b01, 2'b00};
        vecs[3]  = '{1'b1, 2'b11, 1'b0, 3'd2, 1'b1, 1'b1, 2'b01, 2'b00};
        vecs[4]  = '{1'b1, 2'b00, 1'b0, 3'd3, 1'b1, 1'b1, 2'b01, 2'b00};
        vecs[5]  = '{1'b1, 2'b11, 1'b0, 3'd4, 1'b1, 1'b0, 2'b01, 2'b00};
        vecs[6]  = '{1'b1, 2'b11, 1'b0, 3'd4, 1'b1, 1'b0, 2'b01, 2'b00};
        vecs[7]  = '{1'b0, 2'b00, 1'b1, 3'd4, 1'b1, 1'b0, 2'b01, 2'b00};
        vecs[8]  = '{1'b0, 2'b00, 1'b1, 3'd3, 1'b1, 1'b1, 2'b10, 2'b01};
        vecs[9]  = '{1'b0, 2'b00, 1'b1, 3'd2, 1'b1, 1'b1, 2'b11, 2'b11};
        vecs[10] = '{1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b1, 2'b00, 2'b00};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 3'd0, 1'b0, 1'b1, 2'b01, 2'b00};
        vecs[12] = '{1'b1, 2'b10, 1'b0, 3'd0, 1'b0, 1'b1, 2'b01, 2'b00};
        vecs[13] = '{1'b1, 2'b01, 1'b0, 3'd1, 1'b1, 1'b1, 2'b10, 2'b00};
        vecs[14] = '{1'b1, 2'b11, 1'b0, 3'd2, 1'b1, 1'b1, 2'b10, 2'b00};
        vecs[15] = '{1'b1, 2'b10, 1'b0, 3'd3, 1'b1, 1'b1, 2'b10, 2'b00};
        vecs[16] = '{1'b1, 2'b00, 1'b1, 3'd4, 1'b1, 1'b0, 2'b10, 2'b00};
        vecs[17] = '{1'b1, 2'b00, 1'b1, 3'd3, 1'b1, 1'b1, 2'b01, 2'b10};
        vecs[18] = '{1'b0, 2'b00, 1'b0, 3'd3, 1'b1, 1'b1, 2'b11, 2'b11};
        vecs[19] = '{1'b0, 2'b00, 1'b1, 3'd3, 1'b1, 1'b1, 2'b11, 2'b11};
        vecs[20] = '{1'b0, 2'b00, 1'b1, 3'd2, 1'b1, 1'b1, 2'b10, 2'b00};
        vecs[21] = '{1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b1, 2'b00, 2'b10};
        vecs[22] = '{1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b1, 2'b01, 2'b10};

        do_reset();

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].ordy);
            chk_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].ov,
                    vecs[i].ir, vecs[i].od, vecs[i].xa);
        end

        // Continuous streaming through the wrapping pointers.
        do_reset();
        q.delete();
        model_acc = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            w = 2'(i % 4);
            drive(1'b1, w, 1'b1);
            chk($sformatf("wrap%0d.level", i), 32'(level), 32'(q.size()));
            chk($sformatf("wrap%0d.xor", i), 32'(xor_acc), 32'(model_acc));
            if (q.size() > 0) begin
                chk($sformatf("wrap%0d.data", i), 32'(out_data), 32'(q[0]));
                model_acc = model_acc ^ q[0];
                void'(q.pop_front());
            end
            q.push_back(w);
        end
        drive(1'b0, 2'b00, 1'b0);
        chk("wrap_end.level", 32'(level), 32'd1);
        chk("wrap_end.xor", 32'(xor_acc), 32'h1);
        chk("wrap_end.data", 32'(out_data), 32'h2);

        // Build level 3, then drop reset between edges.
        drive(1'b1, 2'b11, 1'b0);
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b0, 2'b00, 1'b0);
        chk_all("pre_rst", 3'd3, 1'b1, 1'b1, 2'b10, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 3'd0, 1'b0, 1'b1, 2'b00, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 2'b11, 1'b0);
        chk_all("post_rst0", 3'd0, 1'b0, 1'b1, 2'b00, 2'b00);
        drive(1'b0, 2'b00, 1'b1);
        chk_all("post_rst1", 3'd1, 1'b1, 1'b1, 2'b11, 2'b00);
        drive(1'b0, 2'b00, 1'b0);
        chk_all("post_rst2", 3'd0, 1'b0, 1'b1, 2'b00, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
